hilo_div_sequencer: RTL and testbench

- Multi-cycle controller for the unsigned divider and the HI/LO register pair in the EX stage.
- On a DIVU it launches the divider, counts the iteration cycles, and commits the 64-bit quotient/remainder into HI/LO with a one-cycle write strobe.
- While a divide is outstanding, it stalls any later DIVU, MFHI or MFLO in EX.
- It handles divide-by-zero and pipeline flush without corrupting HI/LO.

---
 rtl/hilo_div_sequencer.sv | 88 ++++++++
 tb/tb_hilo_div_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_sequencer.sv
// EX-stage sequencer for the multi-cycle unsigned divider and HI/LO commit.
// Launches DIVU, counts iterations, strobes HI/LO write, stalls dependent ops.
module hilo_div_sequencer #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_req,
  input  logic             divisor_zero,
  input  logic             mf_req,
  input  logic             flush,
  output logic             div_start,
  output logic             div_busy,
  output logic             hilo_we,
  output logic             stall,
  output logic             div_err,
  output logic [CNT_W-1:0] cycles_left
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             start_nx, err_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cycles_left <= '0;
      div_start   <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      cycles_left <= cnt_nx;
      div_start   <= start_nx;
      div_err     <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cycles_left;
    start_nx = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        // flush kills the EX instruction, so neither launch nor error
        if (div_req && !flush) begin
          if (divisor_zero) begin
            err_nx = 1'b1;
          end else begin
            state_nx = RUN;
            cnt_nx   = CNT_LOAD;
            start_nx = 1'b1;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cycles_left == '0) begin
          state_nx = WRITE;
        end else begin
          cnt_nx = cycles_left - 1'b1;
        end
      end
      WRITE: begin
        // commit is already architecturally visible; flush does not abort it
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign div_busy = (state == RUN) || (state == WRITE);
  assign hilo_we  = (state == WRITE);
  assign stall    = (state != IDLE) && (div_req || mf_req);

endmodule

// File: tb/tb_hilo_div_sequencer.sv
// Directed bench for hilo_div_sequencer with a behavioural divider + HI/LO pair.
module tb_hilo_div_sequencer;

  logic       clk = 1'b0;
  logic       reset, div_req, divisor_zero, mf_req, flush;
  logic       div_start, div_busy, hilo_we, stall, div_err;
  logic [7:0] cycles_left;

  logic [31:0] a = 32'd0, b = 32'd1;
  logic [31:0] ma = 32'd0, mb = 32'd1, hi = 32'd0, lo = 32'd0;
  int total = 0, bad = 0;
  int n, cnt, gap;

  always #5 clk = ~clk;

  hilo_div_sequencer #(.DIV_CYCLES(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .div_req(div_req), .divisor_zero(divisor_zero),
    .mf_req(mf_req), .flush(flush), .div_start(div_start), .div_busy(div_busy),
    .hilo_we(hilo_we), .stall(stall), .div_err(div_err), .cycles_left(cycles_left)
  );

  // divider environment: operands captured on div_start, result written on hilo_we
  always @(posedge clk) begin
    if (div_start) begin ma <= a; mb <= b; end
    if (hilo_we) begin hi <= ma % mb; lo <= ma / mb; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_we(input string tag);
    int k = 0;
    while (hilo_we !== 1'b1 && k < 100) begin tick(); k++; end
    chk(tag, hilo_we, 1'b1);
  endtask

  task automatic wait_cl(input string tag, input logic [7:0] v);
    int k = 0;
    while (!(div_busy === 1'b1 && hilo_we === 1'b0 && cycles_left === v) && k < 100) begin
      tick(); k++;
    end
    chk(tag, cycles_left, v);
  endtask

  initial begin
    reset = 1'b0; div_req = 1'b0; divisor_zero = 1'b0; mf_req = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", div_busy, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_we", hilo_we, 1'b0);
    chk("rst_start", div_start, 1'b0);
    chk("rst_err", div_err, 1'b0);
    chk("rst_cl", cycles_left, 8'd0);
    mf_req = 1'b0;
    reset = 1'b1;
    tick();

    // 1: 100/7, full latency
    a = 32'd100; b = 32'd7; div_req = 1'b1;
    #1 chk("s1_idle_stall", stall, 1'b0);
    tick();
    chk("s1_start", div_start, 1'b1);
    chk("s1_cl_load", cycles_left, 8'd31);
    div_req = 1'b0;
    n = 1; cnt = 1; gap = 1;  // cnt: start pulses, gap: busy cycles
    mf_req = 1'b0;
    begin
      int st = 0;
      while (hilo_we !== 1'b1 && n < 100) begin
        tick(); n++; cnt += div_start; gap += div_busy; st += stall;
      end
      chk("s1_no_stall", st, 0);
    end
    chk("s1_we_cycle", n, 33);
    chk("s1_start_once", cnt, 1);
    chk("s1_busy_cycles", gap, 33);
    tick();
    chk("s1_busy_off", div_busy, 1'b0);
    chk("s1_hi", hi, 32'd2);
    chk("s1_lo", lo, 32'd14);

    // 2: MFLO arrives mid-RUN, stalls through WRITE
    div_req = 1'b1;
    tick();
    div_req = 1'b0;
    wait_cl("s2_reach", 8'd26);
    mf_req = 1'b1;
    #1 cnt = 0; n = 0;
    while (div_busy === 1'b1 && n < 100) begin cnt += stall; tick(); n++; end
    chk("s2_stall_cycles", cnt, 28);
    chk("s2_idle_stall", stall, 1'b0);
    chk("s2_lo", lo, 32'd14);
    mf_req = 1'b0;

    // 4: zero divisor dropped with error pulse
    div_req = 1'b1; divisor_zero = 1'b1;
    #1 chk("s4_stall", stall, 1'b0);
    tick();
    chk("s4_err", div_err, 1'b1);
    chk("s4_start", div_start, 1'b0);
    chk("s4_busy", div_busy, 1'b0);
    div_req = 1'b0; divisor_zero = 1'b0;
    tick();
    chk("s4_err_off", div_err, 1'b0);
    chk("s4_hi", hi, 32'd2);
    chk("s4_lo", lo, 32'd14);

    // flush in IDLE overrides request
    div_req = 1'b1; divisor_zero = 1'b1; flush = 1'b1;
    tick();
    chk("fi_err", div_err, 1'b0);
    divisor_zero = 1'b0;
    tick();
    chk("fi_start", div_start, 1'b0);
    chk("fi_busy", div_busy, 1'b0);
    div_req = 1'b0; flush = 1'b0;

    // 3: back-to-back divides
    a = 32'd100; b = 32'd7; div_req = 1'b1;
    tick();
    div_req = 1'b0;
    tick(); tick();
    a = 32'hFFFF_FFFF; b = 32'd16; div_req = 1'b1;
    #1 chk("s3_stall", stall, 1'b1);
    wait_we("s3_we1");
    chk("s3_stall_write", stall, 1'b1);
    gap = 0;
    // one IDLE accept cycle lies between the WRITE and the new start pulse
    while (div_start !== 1'b1 && gap < 10) begin tick(); gap++; end
    chk("s3_gap", gap, 2);
    chk("s3_cl_load", cycles_left, 8'd31);
    div_req = 1'b0;
    wait_we("s3_we2");
    tick();
    chk("s3_hi", hi, 32'd15);
    chk("s3_lo", lo, 32'h0FFF_FFFF);

    // 5: flush mid-RUN discards the result
    a = 32'd9; b = 32'd2; div_req = 1'b1;
    tick();
    div_req = 1'b0;
    wait_cl("s5_reach", 8'd22);
    flush = 1'b1;
    tick();
    chk("s5_busy", div_busy, 1'b0);
    chk("s5_cl", cycles_left, 8'd0);
    chk("s5_we", hilo_we, 1'b0);
    flush = 1'b0;
    cnt = 0;
    repeat (40) begin tick(); cnt += hilo_we; end
    chk("s5_no_we", cnt, 0);
    chk("s5_hi", hi, 32'd15);

    // flush coincident with the last RUN cycle wins
    div_req = 1'b1;
    tick();
    div_req = 1'b0;
    wait_cl("s5b_reach", 8'd0);
    flush = 1'b1;
    tick();
    chk("s5b_busy", div_busy, 1'b0);
    chk("s5b_we", hilo_we, 1'b0);
    flush = 1'b0;
    tick();
    chk("s5b_we2", hilo_we, 1'b0);
    chk("s5b_lo", lo, 32'h0FFF_FFFF);

    // flush during WRITE does not abort the commit
    div_req = 1'b1;
    tick();
    div_req = 1'b0;
    wait_we("s5c_we");
    flush = 1'b1;
    #1 chk("s5c_we_held", hilo_we, 1'b1);
    tick();
    chk("s5c_busy", div_busy, 1'b0);
    chk("s5c_hi", hi, 32'd1);
    chk("s5c_lo", lo, 32'd4);
    flush = 1'b0;

    // 6: asynchronous reset mid-RUN
    a = 32'd100; b = 32'd7; div_req = 1'b1;
    tick();
    div_req = 1'b0;
    repeat (5) tick();
    mf_req = 1'b1;
    #1 chk("s6_stall_pre", stall, 1'b1);
    reset = 1'b0;
    #1;
    chk("s6_busy", div_busy, 1'b0);
    chk("s6_stall", stall, 1'b0);
    chk("s6_cl", cycles_left, 8'd0);
    #3 reset = 1'b1;
    mf_req = 1'b0;
    cnt = 0;
    repeat (40) begin tick(); cnt += hilo_we; end
    chk("s6_no_we", cnt, 0);
    chk("s6_lo", lo, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
